register_transfer_sequencer: RTL and testbench
==============================================

REGISTER_TRANSFER_SEQUENCER -- requirements
Module: register_transfer_sequencer

Interface
REQ-001 SHALL have parameter NUM_REG, default 8: number of registers on the shared data bus (A,B,C,D,M1,M2,X,Y order, index 0..7).
REQ-002 SHALL have parameter IDX_W, default 3: width of register index fields; NUM_REG SHALL be no greater than 2**IDX_W.
REQ-003 SHALL have parameter SETTLE, default 2, range 1..15: cycles the source select is held before load asserts.
REQ-004 SHALL have parameter LOAD_CYC, default 2, range 1..15: cycles the destination load is held.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk, input, 1: sole clock, all state updates on rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-008 SHALL have port start, input, 1: request a transfer; sampled only in IDLE.
REQ-009 SHALL have port clr, input, 1: qualifies start; 1 means load zero into dst with no source selected.
REQ-010 SHALL have port src, input, IDX_W: source register index; ignored when clr=1.
REQ-011 SHALL have port dst, input, IDX_W: destination register index.
REQ-012 SHALL have port sel, output, NUM_REG: one-hot-or-zero source select (drives register sel).
REQ-013 SHALL have port load, output, NUM_REG: one-hot-or-zero destination load (drives register load; hold = !load).
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-015 SHALL have port done, output, 1: one-cycle pulse at transfer completion.
REQ-016 SHALL have port err, output, 1: one-cycle pulse on rejected request.

Function
REQ-017 SHALL implement states IDLE, SELECT, LOAD, RELEASE, DONE; all outputs registered.
REQ-018 In IDLE with start=1 and a valid request, SHALL capture src, dst, clr into internal registers and enter SELECT next cycle; later input changes ignored until return to IDLE.
REQ-019 Request invalid if dst>=NUM_REG, or clr=0 and src>=NUM_REG, or clr=0 and src==dst; SHALL stay in IDLE and pulse err the next cycle, no sel/load activity.
REQ-020 SELECT SHALL last exactly SETTLE cycles with sel[src]=1 (sel=0 if clr), load=0.
REQ-021 LOAD SHALL last exactly LOAD_CYC cycles with sel unchanged from SELECT and load[dst]=1.
REQ-022 RELEASE SHALL last 1 cycle with load=0 and sel unchanged, so bus data remains valid while the destination latches.
REQ-023 DONE SHALL last 1 cycle with sel=0, load=0, done=1, busy=1; then IDLE.
REQ-024 Latency: start accepted at edge t -> sel valid t+1..t+SETTLE, load valid t+SETTLE+1..t+SETTLE+LOAD_CYC, done at t+SETTLE+LOAD_CYC+2; next start accepted at t+SETTLE+LOAD_CYC+3.
REQ-025 start while busy=1 SHALL be ignored (no queueing, no err).
REQ-026 At most one bit of sel and one bit of load SHALL be high in any cycle; load SHALL never be high in a cycle where sel differs from its SELECT-phase value.
REQ-027 Cycle counter SHALL be wide enough for max(SETTLE,LOAD_CYC) and reload at each state entry; no wrap-around.

Reset
REQ-028 reset=1 at an edge SHALL force IDLE and sel=0, load=0, busy=0, done=0, err=0 in the following cycle, including mid-transfer (partial load abandoned).
REQ-029 reset SHALL take priority over start in the same cycle; start in the first cycle after reset deasserts SHALL be accepted.

Verification
REQ-030 Defaults, start=1 src=1 dst=4 clr=0 at t -> sel=0x02 t+1..t+4, load=0x10 t+3..t+4, sel=0x02/load=0 t+5, done=1 t+6, busy=0 t+7.
REQ-031 start=1 clr=1 dst=7 -> sel=0x00 throughout, load=0x80 for 2 cycles, done after 6 cycles.
REQ-032 start=1 src=3 dst=3 clr=0 -> err=1 one cycle, busy=0, sel=load=0.
REQ-033 second start at t+2 with src=0 dst=1 during transfer -> ignored; outputs match single transfer of REQ-030.
REQ-034 reset=1 at t+3 during REQ-030 transfer -> all outputs 0 at t+4, busy=0; new start at t+5 completes normally.
REQ-035 SETTLE=1 LOAD_CYC=1, back-to-back starts held high -> done every 5 cycles, invariant REQ-026 checked every cycle.

Source files
------------

// File: rtl/register_transfer_sequencer.sv
// Register transfer sequencer: moves one register onto a shared bus and loads it into another.
// Each transfer is sequenced so the bus settles before the load and stays valid after it:
// SELECT drives the source for SETTLE cycles, LOAD pulses the destination for LOAD_CYC cycles,
// RELEASE keeps the source driven for one cycle while the destination latches, then DONE.
//
// Ports:
//   clk    - sole clock, rising edge
//   reset  - synchronous active-high reset
//   start  - transfer request, sampled only while idle
//   clr    - with start: load zero into dst, no source selected
//   src    - source register index (ignored when clr=1)
//   dst    - destination register index
//   sel    - one-hot-or-zero source select
//   load   - one-hot-or-zero destination load
//   busy   - high in every state except idle
//   done   - one-cycle pulse at transfer completion
//   err    - one-cycle pulse on a rejected request
module register_transfer_sequencer #(
  parameter int unsigned NUM_REG  = 8,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned SETTLE   = 2,
  parameter int unsigned LOAD_CYC = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               clr,
  input  logic [IDX_W-1:0]   src,
  input  logic [IDX_W-1:0]   dst,
  output logic [NUM_REG-1:0] sel,
  output logic [NUM_REG-1:0] load,
  output logic               busy,
  output logic               done,
  output logic               err
);

  // The counter holds remaining cycles minus one, so it never needs to reach MAX_CYC.
  localparam int unsigned MAX_CYC = (SETTLE > LOAD_CYC) ? SETTLE : LOAD_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [IDX_W:0] NumRegW = (IDX_W + 1)'(NUM_REG);

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StLoad,
    StRelease,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   src_q, src_d;
  logic [IDX_W-1:0]   dst_q, dst_d;
  logic               clr_q, clr_d;
  logic [NUM_REG-1:0] sel_q, sel_d;
  logic [NUM_REG-1:0] load_q, load_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               req_valid;
  logic               drive_src;

  // Index comparisons are done one bit wider so NUM_REG == 2**IDX_W is representable.
  always_comb begin
    req_valid = ({1'b0, dst} < NumRegW) &&
                (clr || (({1'b0, src} < NumRegW) && (src != dst)));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    dst_d   = dst_q;
    clr_d   = clr_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (req_valid) begin
            state_d = StSelect;
            cnt_d   = CNT_W'(SETTLE - 1);
            src_d   = src;
            dst_d   = dst;
            clr_d   = clr;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StSelect: begin
        if (cnt_q == '0) begin
          state_d = StLoad;
          cnt_d   = CNT_W'(LOAD_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StLoad: begin
        if (cnt_q == '0) begin
          state_d = StRelease;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StRelease: begin
        state_d = StDone;
        cnt_d   = '0;
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    sel_d     = '0;
    load_d    = '0;
    drive_src = ((state_d == StSelect) || (state_d == StLoad) || (state_d == StRelease)) &&
                !clr_d;
    for (int i = 0; i < NUM_REG; i++) begin
      sel_d[i]  = drive_src && (src_d == IDX_W'(i));
      load_d[i] = (state_d == StLoad) && (dst_d == IDX_W'(i));
    end
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      clr_q   <= 1'b0;
      sel_q   <= '0;
      load_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      clr_q   <= clr_d;
      sel_q   <= sel_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign sel  = sel_q;
  assign load = load_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_register_transfer_sequencer.sv
// Testbench for register_transfer_sequencer: a default-parameter instance plus a
// SETTLE=1/LOAD_CYC=1 instance. Expected per-cycle outputs are queued when stimulus
// is driven and popped as each cycle's outputs appear.
module tb_register_transfer_sequencer;

  typedef struct packed {
    logic [7:0] sel;
    logic [7:0] load;
    logic       busy;
    logic       done;
    logic       err;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, clr;
  logic [2:0] src, dst;
  logic       start2, clr2;
  logic [2:0] src2, dst2;
  logic [7:0] sel1, load1, sel2, load2;
  logic       busy1, done1, err1, busy2, done2, err2;
  obs_t       obs1, obs2;
  obs_t       q1[$];
  obs_t       q2[$];
  int         compared = 0;
  int         failed = 0;
  bit         mon_en = 1'b0;
  logic [7:0] prev_sel1, prev_sel2;

  always #5 clk = ~clk;

  register_transfer_sequencer dut1 (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .clr   (clr),
    .src   (src),
    .dst   (dst),
    .sel   (sel1),
    .load  (load1),
    .busy  (busy1),
    .done  (done1),
    .err   (err1)
  );

  register_transfer_sequencer #(
    .SETTLE   (1),
    .LOAD_CYC (1)
  ) dut2 (
    .clk   (clk),
    .reset (reset),
    .start (start2),
    .clr   (clr2),
    .src   (src2),
    .dst   (dst2),
    .sel   (sel2),
    .load  (load2),
    .busy  (busy2),
    .done  (done2),
    .err   (err2)
  );

  assign obs1 = {sel1, load1, busy1, done1, err1};
  assign obs2 = {sel2, load2, busy2, done2, err2};

  // Expected outputs of one transfer starting the cycle after start is sampled;
  // only the first 'limit' cycles are queued (for transfers cut short by reset).
  task automatic push_xfer(input int s, input int d, input bit c, input int settle,
                           input int lc, input int limit, input bit which);
    obs_t tmp[$];
    obs_t e;
    logic [7:0] sv, lv;
    sv = c ? 8'h00 : (8'h01 << s);
    lv = 8'h01 << d;
    for (int i = 0; i < settle; i++) begin
      e = {sv, 8'h00, 1'b1, 1'b0, 1'b0};
      tmp.push_back(e);
    end
    for (int i = 0; i < lc; i++) begin
      e = {sv, lv, 1'b1, 1'b0, 1'b0};
      tmp.push_back(e);
    end
    e = {sv, 8'h00, 1'b1, 1'b0, 1'b0};
    tmp.push_back(e);
    e = {8'h00, 8'h00, 1'b1, 1'b1, 1'b0};
    tmp.push_back(e);
    for (int i = 0; i < tmp.size() && i < limit; i++) begin
      if (which) q2.push_back(tmp[i]);
      else q1.push_back(tmp[i]);
    end
  endtask

  task automatic push_idle(input int n, input bit which);
    obs_t e;
    e = '0;
    for (int i = 0; i < n; i++) begin
      if (which) q2.push_back(e);
      else q1.push_back(e);
    end
  endtask

  task automatic push_err();
    obs_t e;
    e = {8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    q1.push_back(e);
  endtask

  task automatic test_reset();
    obs_t exp;
    int n;
    reset = 1'b1;
    start = 1'b1; clr = 1'b0; src = 3'd1; dst = 3'd2;
    start2 = 1'b1; clr2 = 1'b0; src2 = 3'd1; dst2 = 3'd2;
    push_idle(2, 0);
    n = q1.size();
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      mon_en = 1'b1;
      exp = q1.pop_front();
      compared++;
      if (obs1 !== exp) begin
        failed++;
        $display("FAIL reset cyc %0d: got %h want %h", k, obs1, exp);
      end
      compared++;
      if (obs2 !== '0) begin
        failed++;
        $display("FAIL reset_dut2 cyc %0d: got %h want 0", k, obs2);
      end
    end
    reset = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic test_basic();
    obs_t exp;
    int n;
    start = 1'b1; clr = 1'b0; src = 3'd1; dst = 3'd4;
    push_xfer(1, 4, 1'b0, 2, 2, 99, 0);
    push_idle(1, 0);
    n = q1.size();
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      // Changing inputs mid-transfer must not disturb the captured request.
      if (k == 1) begin start = 1'b0; src = 3'd6; dst = 3'd0; clr = 1'b1; end
      exp = q1.pop_front();
      compared++;
      if (obs1 !== exp) begin
        failed++;
        $display("FAIL basic cyc %0d: got %h want %h", k, obs1, exp);
      end
    end
    clr = 1'b0;
  endtask

  task automatic test_clear();
    obs_t exp;
    int n;
    start = 1'b1; clr = 1'b1; src = 3'd3; dst = 3'd7;
    push_xfer(3, 7, 1'b1, 2, 2, 99, 0);
    push_idle(1, 0);
    n = q1.size();
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin start = 1'b0; clr = 1'b0; end
      exp = q1.pop_front();
      compared++;
      if (obs1 !== exp) begin
        failed++;
        $display("FAIL clear cyc %0d: got %h want %h", k, obs1, exp);
      end
    end
  endtask

  task automatic test_error();
    obs_t exp;
    int n;
    // src == dst rejected, then again with different index, then clr makes it legal.
    start = 1'b1; clr = 1'b0; src = 3'd3; dst = 3'd3;
    push_err();
    push_idle(1, 0);
    push_err();
    push_idle(1, 0);
    push_xfer(2, 2, 1'b1, 2, 2, 99, 0);
    push_idle(1, 0);
    n = q1.size();
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
      if (k == 2) begin start = 1'b1; src = 3'd5; dst = 3'd5; end
      if (k == 3) start = 1'b0;
      if (k == 4) begin start = 1'b1; clr = 1'b1; src = 3'd2; dst = 3'd2; end
      if (k == 5) begin start = 1'b0; clr = 1'b0; end
      exp = q1.pop_front();
      compared++;
      if (obs1 !== exp) begin
        failed++;
        $display("FAIL error cyc %0d: got %h want %h", k, obs1, exp);
      end
    end
  endtask

  task automatic test_ignore_busy();
    obs_t exp;
    int n;
    start = 1'b1; clr = 1'b0; src = 3'd1; dst = 3'd4;
    push_xfer(1, 4, 1'b0, 2, 2, 99, 0);
    push_idle(2, 0);
    n = q1.size();
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
      if (k == 2) begin start = 1'b1; src = 3'd0; dst = 3'd1; end
      if (k == 3) start = 1'b0;
      exp = q1.pop_front();
      compared++;
      if (obs1 !== exp) begin
        failed++;
        $display("FAIL ignore_busy cyc %0d: got %h want %h", k, obs1, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t exp;
    int n;
    start = 1'b1; clr = 1'b0; src = 3'd1; dst = 3'd4;
    push_xfer(1, 4, 1'b0, 2, 2, 3, 0);
    push_idle(2, 0);
    push_xfer(2, 6, 1'b0, 2, 2, 99, 0);
    push_idle(1, 0);
    n = q1.size();
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
      if (k == 3) reset = 1'b1;
      if (k == 4) reset = 1'b0;
      if (k == 5) begin start = 1'b1; src = 3'd2; dst = 3'd6; end
      if (k == 6) start = 1'b0;
      exp = q1.pop_front();
      compared++;
      if (obs1 !== exp) begin
        failed++;
        $display("FAIL reset_mid cyc %0d: got %h want %h", k, obs1, exp);
      end
    end
  endtask

  task automatic test_reset_priority();
    obs_t exp;
    int n;
    reset = 1'b1;
    start = 1'b1; clr = 1'b0; src = 3'd0; dst = 3'd2;
    push_idle(1, 0);
    push_xfer(0, 2, 1'b0, 2, 2, 99, 0);
    push_idle(1, 0);
    n = q1.size();
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (k == 1) reset = 1'b0;
      if (k == 2) start = 1'b0;
      exp = q1.pop_front();
      compared++;
      if (obs1 !== exp) begin
        failed++;
        $display("FAIL reset_priority cyc %0d: got %h want %h", k, obs1, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t exp;
    int n;
    start2 = 1'b1; clr2 = 1'b0; src2 = 3'd0; dst2 = 3'd7;
    for (int i = 0; i < 3; i++) begin
      push_xfer(0, 7, 1'b0, 1, 1, 99, 1);
      push_idle(1, 1);
    end
    push_idle(1, 1);
    n = q2.size();
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (k == 15) start2 = 1'b0;
      exp = q2.pop_front();
      compared++;
      if (obs2 !== exp) begin
        failed++;
        $display("FAIL back_to_back cyc %0d: got %h want %h", k, obs2, exp);
      end
    end
  endtask

  // One-hot and load-under-stable-select invariants on both instances, every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      compared++;
      if (!$onehot0(sel1) || !$onehot0(load1)) begin
        failed++;
        $display("FAIL onehot1: got sel=%h load=%h want at most one bit each", sel1, load1);
      end
      compared++;
      if (!$onehot0(sel2) || !$onehot0(load2)) begin
        failed++;
        $display("FAIL onehot2: got sel=%h load=%h want at most one bit each", sel2, load2);
      end
      if (load1 != 8'h00) begin
        compared++;
        if (sel1 !== prev_sel1) begin
          failed++;
          $display("FAIL sel_stable1: got sel=%h want %h during load", sel1, prev_sel1);
        end
      end
      if (load2 != 8'h00) begin
        compared++;
        if (sel2 !== prev_sel2) begin
          failed++;
          $display("FAIL sel_stable2: got sel=%h want %h during load", sel2, prev_sel2);
        end
      end
    end
    prev_sel1 <= sel1;
    prev_sel2 <= sel2;
  end

  initial begin
    test_reset();
    test_basic();
    test_clear();
    test_error();
    test_ignore_busy();
    test_reset_mid();
    test_reset_priority();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
